// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the fetch-side PC logic.
//
// Contents:
//   pc_state_e        sequencer FSM states (BOOT, RUN, HOLD)
//   DEFAULT_RESET_PC  PC loaded while reset is asserted
//   DEFAULT_TRAP_PC   PC loaded on a misaligned jr/branch target when
//                     PC_MISALIGN_TRAP_EN is defined
//   is_misaligned()   true when an address is not word aligned
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_PC  = 32'h0000_0080;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_target_mux.sv
// pc_target_mux -- combinational next-PC selection for pc_sequencer.
//
// Priority among requests is jr > jump > branch_taken > sequential; stall
// is handled by the sequencer, which simply does not load the result.
//
// Ports:
//   pc_plus4_i      current pc + 4
//   jump_lo_i       {instr_index, 2'b00} from the shift stage
//   br_off_i        sign-extended, pre-scaled branch offset
//   jr_addr_i       register jump target
//   jump_i, branch_taken_i, jr_i   request strobes
//   target_o        raw selected target (not yet alignment-checked)
//   nonseq_o        selected target is jr, jump or branch
//   check_align_o   selected target is jr or branch (jump is aligned by
//                   construction, so it is never checked)
import mips_pkg::*;

module pc_target_mux (
  input  logic [31:0] pc_plus4_i,
  input  logic [27:0] jump_lo_i,
  input  logic [31:0] br_off_i,
  input  logic [31:0] jr_addr_i,
  input  logic        jump_i,
  input  logic        branch_taken_i,
  input  logic        jr_i,
  output logic [31:0] target_o,
  output logic        nonseq_o,
  output logic        check_align_o
);

  // Priority select of the next fetch address; sum wraps modulo 2^32.
  always_comb begin
    target_o      = pc_plus4_i;
    nonseq_o      = 1'b0;
    check_align_o = 1'b0;
    if (jr_i) begin
      target_o      = jr_addr_i;
      nonseq_o      = 1'b1;
      check_align_o = 1'b1;
    end else if (jump_i) begin
      target_o      = {pc_plus4_i[31:28], jump_lo_i};
      nonseq_o      = 1'b1;
    end else if (branch_taken_i) begin
      target_o      = pc_plus4_i + br_off_i;
      nonseq_o      = 1'b1;
      check_align_o = 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program counter register, BOOT/RUN/HOLD FSM and the
// redirect/trap pulses.
//
// Optional feature: define PC_MISALIGN_TRAP_EN to send misaligned jr/branch
// targets to TRAP_PC with a one-cycle trap pulse. Without it the target's
// low two bits are cleared and trap stays 0.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   jump_lo, br_off, jr_addr   target sources
//   jump, branch_taken, jr     redirect requests
//   stall             hold the current pc
//   pc, pc_plus4      current fetch address and its successor
//   pc_valid          low only in BOOT
//   redirect, trap    registered single-cycle pulses
import mips_pkg::*;

module pc_sequencer #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_PC  = DEFAULT_TRAP_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [27:0] jump_lo,
  input  logic [31:0] br_off,
  input  logic [31:0] jr_addr,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic        jr,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        redirect,
  output logic        trap
);

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        redirect_q, redirect_d;
  logic        trap_q, trap_d;

  logic [31:0] target;
  logic        nonseq;
  logic        check_align;
  logic        misaligned;

  assign pc_plus4 = pc_q + 32'd4;

  pc_target_mux u_mux (
    .pc_plus4_i     (pc_plus4),
    .jump_lo_i      (jump_lo),
    .br_off_i       (br_off),
    .jr_addr_i      (jr_addr),
    .jump_i         (jump),
    .branch_taken_i (branch_taken),
    .jr_i           (jr),
    .target_o       (target),
    .nonseq_o       (nonseq),
    .check_align_o  (check_align)
  );

  assign misaligned = check_align && is_misaligned(target);

  // Next-state logic: BOOT always moves to RUN without loading; RUN and
  // HOLD behave identically once stall drops, so a release from HOLD uses
  // the same request priority as a normal RUN cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    trap_d     = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN, HOLD: begin
        if (stall) begin
          state_d = HOLD;
        end else begin
          state_d = RUN;
          if (TRAP_EN && misaligned) begin
            pc_d   = TRAP_PC;
            trap_d = 1'b1;
          end else begin
            pc_d       = misaligned ? {target[31:2], 2'b00} : target;
            redirect_d = nonseq;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State, pc and pulse registers; reset acts immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      trap_q     <= trap_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = (state_q != BOOT);
  assign redirect = redirect_q;
  assign trap     = TRAP_EN ? trap_q : 1'b0;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- directed scenarios plus random traffic for
// pc_sequencer, compared every cycle against a behavioural model that
// tracks only the architectural pc and the expected pulses.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [27:0] jump_lo;
  logic [31:0] br_off;
  logic [31:0] jr_addr;
  logic        jump;
  logic        branch_taken;
  logic        jr;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        redirect;
  logic        trap;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] mPc;
  bit          mBoot;
  bit          mRedirect;
  bit          mTrap;

  pc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .jump_lo      (jump_lo),
    .br_off       (br_off),
    .jr_addr      (jr_addr),
    .jump         (jump),
    .branch_taken (branch_taken),
    .jr           (jr),
    .stall        (stall),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .pc_valid     (pc_valid),
    .redirect     (redirect),
    .trap         (trap)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("pc", pc, mPc);
    checkOutput("pc_plus4", pc_plus4, mPc + 32'd4);
    checkOutput("pc_valid", {31'b0, pc_valid}, {31'b0, !mBoot});
    checkOutput("redirect", {31'b0, redirect}, {31'b0, mRedirect});
    checkOutput("trap", {31'b0, trap}, {31'b0, mTrap});
  endtask

  // One clock of architectural behaviour: boot cycle, stalled cycle, or a
  // load of the highest-priority target.
  task automatic modelStep();
    logic [31:0] plus4;
    logic [31:0] tgt;
    bit          nonseq;
    bit          chk;
    if (mBoot) begin
      mBoot = 0; mRedirect = 0; mTrap = 0;
    end else if (stall) begin
      mRedirect = 0; mTrap = 0;
    end else begin
      plus4  = mPc + 32'd4;
      nonseq = 1; chk = 1;
      if (jr)                tgt = jr_addr;
      else if (jump)         begin tgt = {plus4[31:28], jump_lo}; chk = 0; end
      else if (branch_taken) tgt = plus4 + br_off;
      else                   begin tgt = plus4; chk = 0; nonseq = 0; end
`ifdef PC_MISALIGN_TRAP_EN
      if (chk && tgt[1:0] != 2'b00) begin
        mPc = 32'h0000_0080; mTrap = 1; mRedirect = 0;
      end else begin
        mPc = tgt; mTrap = 0; mRedirect = nonseq;
      end
`else
      if (chk) tgt[1:0] = 2'b00;
      mPc = tgt; mTrap = 0; mRedirect = nonseq;
`endif
    end
  endtask

  // Drive inputs just after a falling edge, let one rising edge happen,
  // then compare everything at the next falling edge.
  task automatic applyStimulus(input bit s, input bit j, input bit jp,
                               input bit b, input logic [31:0] jra,
                               input logic [27:0] jlo, input logic [31:0] off);
    stall = s; jr = j; jump = jp; branch_taken = b;
    jr_addr = jra; jump_lo = jlo; br_off = off;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 32'h0, 28'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] held;
    rst_n = 1'b0;
    stall = 0; jr = 0; jump = 0; branch_taken = 0;
    jr_addr = '0; jump_lo = '0; br_off = '0;
    mPc = 32'h0; mBoot = 1; mRedirect = 0; mTrap = 0;

    // Reset state
    #2;
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_valid", {31'b0, pc_valid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkAll();
    checkOutput("boot_valid", {31'b0, pc_valid}, 32'h0);

    // Boot sequence: pc 0, 4, 8
    idle(); checkOutput("seq0", pc, 32'h0);
    checkOutput("run_valid", {31'b0, pc_valid}, 32'h1);
    idle(); checkOutput("seq4", pc, 32'h4);
    idle(); checkOutput("seq8", pc, 32'h8);

    // Jump (with branch also asserted) from 0x1000_0010
    applyStimulus(0, 1, 0, 0, 32'h1000_0010, 28'h0, 32'h0);
    checkOutput("jr_pc", pc, 32'h1000_0010);
    applyStimulus(0, 0, 1, 1, 32'h0, 28'h000_0040, 32'h40);
    checkOutput("jump_pc", pc, 32'h1000_0040);
    checkOutput("jump_redir", {31'b0, redirect}, 32'h1);
    idle();
    checkOutput("jump_redir_end", {31'b0, redirect}, 32'h0);

    // Backward branch from 0x100
    applyStimulus(0, 1, 0, 0, 32'h100, 28'h0, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'h0, 28'h0, 32'hFFFF_FFF0);
    checkOutput("branch_pc", pc, 32'h0F4);

    // Stall for three cycles with a jump pending
    held = pc;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 0, 32'h0, 28'h0AB_CDE0, 32'h0);
      checkOutput("stall_pc", pc, held);
    end
    idle();
    checkOutput("unstall_pc", pc, held + 32'd4);
    checkOutput("unstall_redir", {31'b0, redirect}, 32'h0);

    // Misaligned jr target
    applyStimulus(0, 1, 0, 0, 32'h202, 28'h0, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
    checkOutput("mis_pc", pc, 32'h80);
    checkOutput("mis_trap", {31'b0, trap}, 32'h1);
    checkOutput("mis_redir", {31'b0, redirect}, 32'h0);
`else
    checkOutput("mis_pc", pc, 32'h200);
    checkOutput("mis_trap", {31'b0, trap}, 32'h0);
    checkOutput("mis_redir", {31'b0, redirect}, 32'h1);
`endif

    // Wrap-around
    applyStimulus(0, 1, 0, 0, 32'hFFFF_FFFC, 28'h0, 32'h0);
    idle();
    checkOutput("wrap_pc", pc, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      logic [31:0] ro;
      ra = $urandom;
      ro = {$urandom_range(0, 255) > 32 ? 30'($urandom) : 30'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 7) == 0) ro[1:0] = 2'($urandom);
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                    ra, {26'($urandom), 2'b00}, ro);
    end

    // Reset asserted while holding
    applyStimulus(0, 1, 0, 0, 32'h40, 28'h0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 28'h0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 28'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("hold_rst_pc", pc, 32'h0);
    checkOutput("hold_rst_valid", {31'b0, pc_valid}, 32'h0);
    checkOutput("hold_rst_redir", {31'b0, redirect}, 32'h0);
    checkOutput("hold_rst_trap", {31'b0, trap}, 32'h0);
    mPc = 32'h0; mBoot = 1; mRedirect = 0; mTrap = 0;
    @(negedge clk);
    stall = 0;
    rst_n = 1'b1;
    #1;
    checkAll();
    idle(); checkOutput("reboot0", pc, 32'h0);
    idle(); checkOutput("reboot4", pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter TRAP_PC, default 32'h0000_0080, is the PC value loaded on a misaligned-target trap (used only when PC_MISALIGN_TRAP_EN is defined).
REQ-003 The port list SHALL be:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- jump_lo  input  28  jump-target low bits from the shift stage, {instr_index,2'b00}.
- br_off  input  32  sign-extended branch offset, already multiplied by 4.
- jr_addr  input  32  register jump target.
- jump  input  1  J/JAL request.
- branch_taken  input  1  taken conditional branch.
- jr  input  1  JR/JALR request.
- stall  input  1  hold the current PC.
- pc  output  32  current fetch address.
- pc_plus4  output  32  pc + 4, combinational.
- pc_valid  output  1  pc is a valid fetch address.
- redirect  output  1  registered pulse, high for one cycle after a non-sequential load.
- trap  output  1  registered pulse, high for one cycle on a misaligned target; tied 0 when the feature is compiled out.

Function
REQ-004 The block SHALL implement a three-state FSM: BOOT, RUN, HOLD.
REQ-005 BOOT SHALL last exactly one cycle after reset release, with pc=RESET_PC and pc_valid=0, and SHALL then go to RUN with pc unchanged.
REQ-006 In RUN, next-PC priority SHALL be: stall > jr > jump > branch_taken > sequential.
REQ-007 The next-PC values SHALL be:
- jr: jr_addr.
- jump: {pc_plus4[31:28], jump_lo}.
- branch: pc_plus4 + br_off, mod 2^32.
- sequential: pc_plus4.
REQ-008 When stall=1 in RUN, the FSM SHALL go to HOLD with pc unchanged, and any jump, jr or branch request in that cycle SHALL be ignored.
REQ-009 In HOLD, pc SHALL hold; the FSM SHALL return to RUN on the first cycle with stall=0, and next-PC selection in that cycle SHALL follow REQ-006.
REQ-010 pc_valid SHALL be 1 in RUN and HOLD and 0 in BOOT.
REQ-011 redirect SHALL be 1 in the cycle after pc is loaded from jr, jump or branch, and 0 otherwise.
REQ-012 Arithmetic SHALL be 32-bit unsigned with wrap-around: pc=32'hFFFF_FFFC sequential gives 32'h0000_0000.
REQ-013 When jump and branch_taken are asserted together, jump SHALL win, and redirect SHALL be a single pulse.

Reset
REQ-014 Assertion of rst_n=0 SHALL immediately force pc=RESET_PC, the FSM to BOOT, and pc_valid, redirect and trap to 0, including mid-HOLD or mid-redirect.
REQ-015 After rst_n deasserts, the BOOT cycle SHALL occur on the first clock edge.

Configuration
REQ-016 With PC_MISALIGN_TRAP_EN defined, a selected jr or branch target with bits [1:0] != 0 SHALL load TRAP_PC instead of that target, pulse trap for one cycle, and leave redirect=0.
REQ-017 With PC_MISALIGN_TRAP_EN undefined, the target SHALL be loaded with bits [1:0] forced to 0, and trap SHALL be constant 0.

Structure
REQ-018 The FSM state enum, the reset-PC constant and the trap-PC constant SHALL live in the shared package mips_pkg.
REQ-019 One sub-module, pc_target_mux, SHALL hold the combinational next-PC selection; pc_sequencer SHALL hold the register, FSM and pulses.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset release, no requests -> BOOT for 1 cycle with pc=0 and pc_valid=0, then pc=0,4,8.
- pc=32'h1000_0010, jump=1, jump_lo=28'h000_0040 -> next pc=32'h1000_0040, redirect pulses once.
- pc=32'h100, branch_taken=1, br_off=32'hFFFF_FFF0 -> next pc=32'h0F4.
- stall=1 for 3 cycles with jump=1 during the stall -> pc constant throughout and jump ignored; after stall=0, pc advances by 4.
- jr=1 with jr_addr=32'h202, macro defined -> pc=32'h80 and trap pulses; macro undefined -> pc=32'h200 and trap=0.
- rst_n pulled low mid-HOLD -> pc=0 immediately, then the BOOT sequence repeats.
